mod_addsub_ctrl: RTL and testbench
==================================

// Module: mod_addsub_ctrl
// PURPOSE
//  Sequencer that drives the wide adder's start/subtract/done interface as initiator.
//  Computes (a+b) mod M or (a-b) mod M from two chained adder operations:
//  raw add/sub, then a correction by -M or +M.
//  Sits between the exponentiation/Montgomery control logic and one adder instance.
// PARAMETERS
//  N  514  operand width; adder operands are N bits, adder result is N+1 bits
// PORTS
//  clk           in   1    clock; all logic on posedge
//  resetn        in   1    synchronous reset, active-low
//  start         in   1    request; accepted only in IDLE
//  subtract      in   1    0: (a+b) mod M, 1: (a-b) mod M; sampled with start
//  in_a          in   N    operand a; caller guarantees a < M
//  in_b          in   N    operand b; caller guarantees b < M
//  in_m          in   N    modulus M; caller guarantees M > 0
//  result        out  N    modular result; held until the next accepted start
//  done          out  1    one-cycle pulse: result valid
//  busy          out  1    high from the cycle after acceptance until the cycle done pulses
//  add_start     out  1    one-cycle request to adder
//  add_subtract  out  1    adder operation select
//  add_in_a      out  N    adder operand a
//  add_in_b      out  N    adder operand b
//  add_result    in   N+1  adder result, two's complement; bit N is the sign
//  add_done      in   1    adder result valid
// BEHAVIOUR
//  Reset: state=IDLE, result=0, done=0, busy=0, add_start=0, add_subtract=0, add_in_a=0, add_in_b=0.
//  Accept: on start=1 in IDLE, latch a, b, M and op into internal registers. start outside IDLE is ignored.
//  States and transitions:
//   IDLE -> ISSUE1 on start.
//   ISSUE1: add_start=1 for one cycle; operands {a,b}; add_subtract=op. -> WAIT1.
//   WAIT1: on the first cycle with add_done=1, store r1=add_result.
//    add:                 -> ISSUE2.
//    sub, r1[N]=1:        -> ISSUE2.
//    sub, r1[N]=0:        -> FIN with result=r1[N-1:0].
//   ISSUE2: add_start=1 for one cycle.
//    add: operands {r1[N-1:0], M}, subtract=1.
//    sub: operands {r1[N-1:0], M}, subtract=0.
//    -> WAIT2.
//   WAIT2: on the first cycle with add_done=1, capture r2.
//    add: result = r2[N]=1 ? r1[N-1:0] : r2[N-1:0].
//    sub: result = r2[N-1:0].
//    -> FIN.
//   FIN: done=1 for one cycle. -> IDLE. A new start is accepted in the following cycle.
//  Adder handshake: add_done is sampled only in WAIT states. Any add_done seen in the add_start cycle itself is ignored.
//  Adder operands are held stable from ISSUE through WAIT exit.
//  Latency with a zero-wait adder (done tied 1, result registered): start in cycle 0.
//   Two adder ops: done in cycle 5.
//   One adder op: done in cycle 3.
//  Width rules:
//   r1, r2 are N+1 bits.
//   Add: r1 = a+b < 2M, so one conditional subtract suffices.
//   Sub: r1 is in (-M, M), so one conditional add suffices.
//   Sign is bit N of the adder result. The +M sub correction wraps mod 2^(N+1); only the low N bits are kept.
//  Inputs outside the a,b < M precondition: result undefined, but the FSM still terminates with done.
//  Reset mid-operation: return to IDLE next edge; all outputs take reset values; a pending adder op is abandoned.
// CONFIGURATION
//  MODADDSUB_CONST_TIME_EN
//   Defined: the sub path always executes ISSUE2/WAIT2 with operands {r1[N-1:0], M}.
//    If r1[N]=0, result=r1 and r2 is discarded.
//    Latency is data-independent: 5 cycles with a zero-wait adder.
//   Undefined: the early exit on non-negative r1 is used, as described above.
// TESTING
//  (tests use N=514 with small values, zero-extended)
//  1. M=13, a=7, b=9, add -> result=3, done at cycle 5, add_start pulsed exactly twice.
//  2. M=13, a=5, b=4, add -> r2 negative, result=9, done at cycle 5.
//  3. M=13, a=3, b=9, sub -> result=7 (-6+13), two adder ops, done at cycle 5.
//  4. M=13, a=9, b=3, sub -> result=6.
//     Macro undefined: one adder op, done at cycle 3.
//     Macro defined: two adder ops, done at cycle 5.
//  5. Adder stub asserting add_done 3 cycles after add_start, case 1 -> result=3.
//     Operands held stable through each wait; done at cycle 9.
//  6. resetn=0 during WAIT1 -> IDLE next edge, all outputs 0; start during busy ignored, result unchanged.

Source files
------------

// File: rtl/mod_addsub_ctrl.sv
// rtl/mod_addsub_ctrl.sv - modular add/sub sequencer driving one wide adder
// Optional build macro: MODADDSUB_CONST_TIME_EN (sub path always runs the +M correction op)
module mod_addsub_ctrl #(
  parameter int N = 514
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         subtract,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic [N-1:0] result,
  output logic         done,
  output logic         busy,
  output logic         add_start,
  output logic         add_subtract,
  output logic [N-1:0] add_in_a,
  output logic [N-1:0] add_in_b,
  input  logic [N:0]   add_result,
  input  logic         add_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE1 = 3'd1,
    S_WAIT1  = 3'd2,
    S_ISSUE2 = 3'd3,
    S_WAIT2  = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  state_t       state, state_nx;
  logic         op_q;      // 0: add, 1: sub
  logic [N-1:0] m_q;       // modulus, needed again for the correction op
  logic [N:0]   r1_q;      // first adder result, kept for the add-path fallback
  logic         early_exit;

  // A non-negative raw difference is already reduced; skip the correction op
`ifdef MODADDSUB_CONST_TIME_EN
  assign early_exit = 1'b0;
`else
  assign early_exit = op_q & ~add_result[N];
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Next-state logic; add_done only matters in the WAIT states
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_ISSUE1;
      S_ISSUE1: state_nx = S_WAIT1;
      S_WAIT1:  if (add_done) state_nx = early_exit ? S_FIN : S_ISSUE2;
      S_ISSUE2: state_nx = S_WAIT2;
      S_WAIT2:  if (add_done) state_nx = S_FIN;
      S_FIN:    state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Control outputs decoded from state
  always_comb begin
    add_start = (state == S_ISSUE1) || (state == S_ISSUE2);
    done      = (state == S_FIN);
    busy      = (state != S_IDLE);
  end

  // Operand/result datapath; adder operands only change on accept or at WAIT1 exit
  always_ff @(posedge clk) begin
    if (!resetn) begin
      op_q         <= 1'b0;
      m_q          <= '0;
      r1_q         <= '0;
      result       <= '0;
      add_subtract <= 1'b0;
      add_in_a     <= '0;
      add_in_b     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q         <= subtract;
            m_q          <= in_m;
            add_in_a     <= in_a;
            add_in_b     <= in_b;
            add_subtract <= subtract;
          end
        end
        S_WAIT1: begin
          if (add_done) begin
            r1_q <= add_result;
            if (early_exit) begin
              result <= add_result[N-1:0];
            end else begin
              // add: subtract M; sub: add M back
              add_in_a     <= add_result[N-1:0];
              add_in_b     <= m_q;
              add_subtract <= ~op_q;
            end
          end
        end
        S_WAIT2: begin
          if (add_done) begin
            if (!op_q) begin
              result <= add_result[N] ? r1_q[N-1:0] : add_result[N-1:0];
            end else begin
`ifdef MODADDSUB_CONST_TIME_EN
              result <= r1_q[N] ? add_result[N-1:0] : r1_q[N-1:0];
`else
              result <= add_result[N-1:0];
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// tb/tb_mod_addsub_ctrl.sv - directed checks of mod_addsub_ctrl with a behavioural adder stub
module tb_mod_addsub_ctrl;
  localparam int N = 514;
  localparam int W = N + 1;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic         subtract;
  logic [N-1:0] in_a, in_b, in_m;
  logic [N-1:0] result;
  logic         done, busy;
  logic         add_start, add_subtract;
  logic [N-1:0] add_in_a, add_in_b;
  logic [N:0]   add_result;
  logic         add_done;

  int checks = 0;
  int failures = 0;

  // Adder stub: registered result; delay 0 means add_done tied high
  int           stub_delay = 0;
  int           stub_cnt = 0;
  logic [N:0]   stub_res = '0;
  logic [N-1:0] lat_a = '0, lat_b = '0;
  int           n_starts = 0;
  int           stab_err = 0;

  always #5 clk = ~clk;

  mod_addsub_ctrl #(.N(N)) dut (
    .clk(clk), .resetn(resetn), .start(start), .subtract(subtract),
    .in_a(in_a), .in_b(in_b), .in_m(in_m), .result(result), .done(done), .busy(busy),
    .add_start(add_start), .add_subtract(add_subtract), .add_in_a(add_in_a),
    .add_in_b(add_in_b), .add_result(add_result), .add_done(add_done)
  );

  assign add_result = stub_res;
  assign add_done   = (stub_delay == 0) ? 1'b1 : (stub_cnt == 1);

  always @(posedge clk) begin
    if (!resetn) begin
      stub_cnt <= 0;
    end else if (add_start) begin
      stub_res <= add_subtract ? ({1'b0, add_in_a} - {1'b0, add_in_b})
                               : ({1'b0, add_in_a} + {1'b0, add_in_b});
      stub_cnt <= stub_delay;
      lat_a    <= add_in_a;
      lat_b    <= add_in_b;
      n_starts <= n_starts + 1;
    end else begin
      if (stub_cnt > 0) begin
        stub_cnt <= stub_cnt - 1;
        if (add_in_a !== lat_a || add_in_b !== lat_b) stab_err <= stab_err + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [N:0] obs, input logic [N:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input int a, input int b, input int m, input logic op,
                        input int delay, input int exp_r, input int exp_cyc, input int exp_st);
    int cyc;
    int s0;
    int e0;
    stub_delay = delay;
    @(negedge clk);
    s0 = n_starts;
    e0 = stab_err;
    in_a = N'(a); in_b = N'(b); in_m = N'(m); subtract = op; start = 1'b1;
    cyc = 0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_cycle"}, W'(cyc), W'(exp_cyc));
    check({tag, "_result"}, {1'b0, result}, W'(exp_r));
    check({tag, "_add_starts"}, W'(n_starts - s0), W'(exp_st));
    check({tag, "_operand_stable"}, W'(stab_err - e0), W'(0));
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    int s0;
    resetn = 1'b0; start = 1'b0; subtract = 1'b0;
    in_a = '0; in_b = '0; in_m = '0;
    repeat (3) @(negedge clk);
    check("rst_result", {1'b0, result}, W'(0));
    check("rst_ctrl", W'({done, busy, add_start, add_subtract}), W'(0));
    check("rst_operands", {1'b0, add_in_a | add_in_b}, W'(0));
    resetn = 1'b1;

    run_op("t1_add_wrap", 7, 9, 13, 1'b0, 0, 3, 5, 2);
    run_op("t2_add_nowrap", 5, 4, 13, 1'b0, 0, 9, 5, 2);
    run_op("t3_sub_neg", 3, 9, 13, 1'b1, 0, 7, 5, 2);
`ifdef MODADDSUB_CONST_TIME_EN
    run_op("t4_sub_pos", 9, 3, 13, 1'b1, 0, 6, 5, 2);
`else
    run_op("t4_sub_pos", 9, 3, 13, 1'b1, 0, 6, 3, 1);
`endif
    run_op("t5_slow_adder", 7, 9, 13, 1'b0, 3, 3, 9, 2);
    run_op("t5b_zero_sum", 0, 0, 1, 1'b0, 0, 0, 5, 2);

    // Reset during WAIT1 with a slow adder
    stub_delay = 3;
    @(negedge clk);
    in_a = N'(7); in_b = N'(9); in_m = N'(13); subtract = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("mid_busy_before_reset", W'(busy), W'(1));
    resetn = 1'b0;
    @(negedge clk);
    check("mid_rst_result", {1'b0, result}, W'(0));
    check("mid_rst_ctrl", W'({done, busy, add_start, add_subtract}), W'(0));
    check("mid_rst_operands", {1'b0, add_in_a | add_in_b}, W'(0));
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_rst_stays_idle", W'({done, busy}), W'(0));

    // Start while busy must be ignored
    @(negedge clk);
    s0 = n_starts;
    in_a = N'(5); in_b = N'(4); in_m = N'(13); subtract = 1'b0; start = 1'b1;
    cyc = 0;
    @(negedge clk); start = 1'b0; cyc = 1;
    @(negedge clk); cyc = 2;
    in_a = N'(1); in_b = N'(1); subtract = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 3;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check("busy_start_done_cycle", W'(cyc), W'(9));
    check("busy_start_result", {1'b0, result}, W'(9));
    repeat (6) @(negedge clk);
    check("busy_start_no_extra_op", W'(n_starts - s0), W'(2));
    check("busy_start_idle", W'(busy), W'(0));
    check("result_held", {1'b0, result}, W'(9));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
